// File: rtl/pseudo_pkg.sv
// pseudo_pkg: shared glyphs, scan states and default sizing for the result display
package pseudo_pkg;
   localparam int DEF_SCAN_DIV = 50000;
   localparam int DEF_DEPTH = 4;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_HEX [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e
   };
   typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} scan_t;
endpackage

// File: rtl/pseudo_hex7seg.sv
// pseudo_hex7seg: nibble to active-low {g,f,e,d,c,b,a} hex glyph
module pseudo_hex7seg
   import pseudo_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);
   // glyph lookup
   always_comb seg = SEG_HEX[nib];
endmodule

// File: rtl/pseudo_result_display.sv
// pseudo_result_display: captures generator results into a history and scans them onto a 4-digit display
module pseudo_result_display
   import pseudo_pkg::*;
#(
   parameter int SCAN_DIV = DEF_SCAN_DIV,
   parameter int DEPTH = DEF_DEPTH,
   localparam int AW = $clog2(DEPTH),
   localparam int SW = $clog2(SCAN_DIV)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          busy,
   input  logic [7:0]    num,
   input  logic          clr,
   input  logic [AW-1:0] sel,
   output logic [6:0]    seg,
   output logic [3:0]    an,
   output logic          new_result,
   output logic [4:0]    count
);
   logic          busy_q;
   logic          fall;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_addr;
   logic [7:0]    mem [DEPTH];
   logic [7:0]    entry;
   logic          valid;
   logic [SW-1:0] scan_cnt;
   scan_t         state;
   scan_t         nxt;
   logic [3:0]    nib;
   logic [6:0]    hex;
   logic [6:0]    nxt_seg;

   assign fall = busy_q & ~busy;
   assign rd_addr = wr_ptr - AW'(1) - sel;
   assign entry = mem[rd_addr];
   assign valid = 5'(sel) < count;
   assign nxt = scan_t'(state + 2'd1);

   // completion detect, write pointer and fill level; clr overrides a coincident capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         wr_ptr <= '0;
         count <= '0;
         new_result <= 1'b0;
      end else begin
         busy_q <= busy;
         new_result <= fall & ~clr;
         if (clr) begin
            wr_ptr <= '0;
            count <= '0;
         end else if (fall) begin
            wr_ptr <= wr_ptr + 1'b1;
            count <= (count == 5'(DEPTH)) ? count : count + 5'd1;
         end
      end
   end

   // history storage; validity is tracked by count, so the array needs no reset
   always_ff @(posedge clk) begin
      if (fall && !clr) mem[wr_ptr] <= num;
   end

   pseudo_hex7seg u_hex (.nib(nib), .seg(hex));

   // contents of the digit about to be lit
   always_comb begin
      nib = (nxt == DIG0) ? entry[3:0] : (nxt == DIG1) ? entry[7:4] : 4'(sel);
      nxt_seg = (nxt == DIG2) ? SEG_BLANK : (nxt == DIG3 || valid) ? hex : SEG_DASH;
   end

   // digit scan: anode and segments reload together on the slot boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         state <= DIG0;
         an <= 4'b1110;
         seg <= SEG_BLANK;
      end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
         scan_cnt <= '0;
         state <= nxt;
         an <= ~(4'b0001 << nxt);
         seg <= nxt_seg;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_pseudo_result_display.sv
// tb_pseudo_result_display: scoreboard bench for capture, history order, clear and scan timing
module tb_pseudo_result_display;
   localparam int SD = 4;
   localparam int DP = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       busy = 1'b0;
   logic [7:0] num = '0;
   logic       clr = 1'b0;
   logic [1:0] sel = '0;
   logic [6:0] seg;
   logic [3:0] an;
   logic       new_result;
   logic [4:0] count;

   int checks = 0;
   int errors = 0;
   int pulses = 0;
   logic [4:0] sb [$];
   logic [7:0] hist [$];
   int mcount = 0;

   pseudo_result_display #(.SCAN_DIV(SD), .DEPTH(DP)) dut (
      .clk(clk), .rst_n(rst_n), .busy(busy), .num(num), .clr(clr), .sel(sel),
      .seg(seg), .an(an), .new_result(new_result), .count(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: return 7'b1000000;
         4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;
         4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;
         4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;
         4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0010000;
         4'ha: return 7'b0001000;
         4'hb: return 7'b0000011;
         4'hc: return 7'b1000110;
         4'hd: return 7'b0100001;
         4'he: return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   function automatic logic [6:0] exp_seg(input int s, input int dig);
      if (dig == 2) return 7'b1111111;
      if (dig == 3) return glyph(4'(s));
      if (s >= mcount) return 7'b0111111;
      return glyph(dig == 0 ? hist[s][3:0] : hist[s][7:4]);
   endfunction

   // scoreboard: each pulse pops the fill level expected after that capture
   always @(negedge clk) begin
      if (rst_n && new_result) begin
         pulses++;
         if (sb.size() == 0) check("spurious_pulse", 1, 0);
         else check("count_at_pulse", count, sb.pop_front());
      end
   end

   task automatic run(input logic [7:0] n, input logic c);
      busy = 1'b1;
      repeat (3) @(negedge clk);
      busy = 1'b0;
      num = n;
      clr = c;
      if (c) begin
         hist.delete();
         mcount = 0;
      end else begin
         hist.push_front(n);
         if (hist.size() > DP) void'(hist.pop_back());
         mcount = (mcount < DP) ? mcount + 1 : mcount;
         sb.push_back(5'(mcount));
      end
      @(negedge clk);
      clr = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic show(input int s, input int dig);
      logic [3:0] tgt;
      int t;
      sel = 2'(s);
      tgt = ~(4'b0001 << dig);
      t = 0;
      while (an == tgt && t < 100) begin @(negedge clk); t++; end
      while (an != tgt && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) check("scan_timeout", t, 0);
      else check($sformatf("sel%0d_dig%0d", s, dig), seg, exp_seg(s, dig));
   endtask

   task automatic show_all(input int s);
      for (int d = 0; d < 4; d++) show(s, d);
   endtask

   task automatic scan_check(input int n);
      logic [3:0] pa;
      logic [6:0] ps;
      int run_len;
      bit started;
      pa = an;
      ps = seg;
      run_len = 0;
      started = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (an != pa) begin
            if (started) check("hold_len", run_len, SD);
            check("an_rotate", an, {pa[2:0], pa[3]});
            run_len = 1;
            started = 1;
         end else begin
            run_len++;
            if (seg != ps) check("seg_ghost", seg, ps);
         end
         pa = an;
         ps = seg;
      end
   endtask

   task automatic do_reset(input logic b);
      rst_n = 1'b0;
      busy = b;
      hist.delete();
      mcount = 0;
      sb.delete();
      repeat (2) @(negedge clk);
      check("rst_an", an, 4'b1110);
      check("rst_seg", seg, 7'h7f);
      check("rst_count", count, 0);
      check("rst_pulse", new_result, 0);
      rst_n = 1'b1;
   endtask

   initial begin
      // no run after reset
      do_reset(1'b0);
      pulses = 0;
      repeat (200) @(negedge clk);
      check("idle_pulses", pulses, 0);
      check("idle_count", count, 0);
      show_all(0);
      scan_check(40);

      // busy already high at release, fall later captured once
      do_reset(1'b1);
      pulses = 0;
      repeat (10) @(negedge clk);
      busy = 1'b0;
      num = 8'h3c;
      hist.push_front(8'h3c);
      mcount = 1;
      sb.push_back(5'd1);
      repeat (5) @(negedge clk);
      check("first_pulses", pulses, 1);
      check("first_count", count, 1);
      show_all(0);

      // fill past depth; oldest overwritten
      clr = 1'b1;
      hist.delete();
      mcount = 0;
      @(negedge clk);
      clr = 1'b0;
      @(negedge clk);
      check("clr_count", count, 0);
      foreach (hist[i]) check("dummy", 0, 0);
      run(8'ha1, 0); run(8'hb2, 0); run(8'hc3, 0); run(8'hd4, 0); run(8'he5, 0);
      check("sat_count", count, 4);
      for (int s = 0; s < 4; s++) show_all(s);

      // clr coincident with fall drops the sample
      pulses = 0;
      run(8'h77, 1);
      check("clrfall_pulses", pulses, 0);
      check("clrfall_count", count, 0);
      show_all(0);
      run(8'h12, 0);
      check("after_clr_count", count, 1);
      show_all(0);
      show_all(1);

      // async reset mid-scan with three entries
      run(8'h9f, 0);
      run(8'h08, 0);
      check("pre_rst_count", count, 3);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_an", an, 4'b1110);
      check("async_seg", seg, 7'h7f);
      check("async_count", count, 0);
      check("async_pulse", new_result, 0);
      hist.delete();
      mcount = 0;
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_count", count, 0);
      check("post_an", an, 4'b1110);
      show_all(0);

      repeat (4) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
